// File: rtl/pattern_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
package pattern_detector_pkg;

  // Widest pattern the mask helper supports; MAX_LEN must not exceed this.
  localparam int unsigned MaskW = 32;

  // State encodings, kept explicit so they stay stable across tools.
  localparam logic [1:0] UnarmedEnc = 2'd0;
  localparam logic [1:0] HuntEnc    = 2'd1;
  localparam logic [1:0] HitEnc     = 2'd2;

  typedef enum logic [1:0] {
    StUnarmed = UnarmedEnc,
    StHunt    = HuntEnc,
    StHit     = HitEnc
  } state_e;

  // Ones in bits [len-1:0]; callers truncate to their own pattern width.
  function automatic logic [MaskW-1:0] len_mask(input int unsigned len);
    logic [MaskW-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < MaskW; b++) begin
      if (b < len) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Configuration, serial data and status bundle for pattern_detector.
interface pattern_detector_if #(
  parameter int unsigned MAX_LEN   = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned LW        = $clog2(MAX_LEN + 1)
);
  logic                 load;
  logic [MAX_LEN-1:0]   pattern_in;
  logic [LW-1:0]        len_in;
  logic                 overlap_en;
  logic                 enable;
  logic                 i;
  logic                 clr_count;
  logic                 match;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 armed;
  logic                 cfg_err;

  modport master (
    output load, pattern_in, len_in, overlap_en, enable, i, clr_count,
    input  match, match_count, armed, cfg_err
  );

  modport slave (
    input  load, pattern_in, len_in, overlap_en, enable, i, clr_count,
    output match, match_count, armed, cfg_err
  );
endinterface

// File: rtl/pattern_detector_hist_shift_reg.sv
// History shift register with a saturating count of bits shifted in.
// Exposes post-shift values so the comparator can judge the incoming bit.
module hist_shift_reg #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               fill_clr,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] hist_nxt_o,
  output logic [LW-1:0]      fill_nxt_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;

  // The oldest bit falls off on the next shift and never reaches a compare.
  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[MAX_LEN-1];

  // Post-shift values and next-state selection: clear beats shift.
  always_comb begin
    hist_nxt_o = {hist_q[MAX_LEN-2:0], bit_in};
    fill_nxt_o = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_nxt_o;
      fill_d = fill_clr ? '0 : fill_nxt_o;
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: loadable pattern, overlap select, Moore match
// flag, saturating match counter and illegal-load reporting.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  pattern_detector_if.slave  bus
);

  state_e               state_q, state_d;
  logic [MAX_LEN-1:0]   pattern_q, pattern_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 overlap_q, overlap_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0]   hist_nxt;
  logic [LW-1:0]        fill_nxt;
  logic [MAX_LEN-1:0]   mask;
  logic                 valid_load, bad_load, consume, completing, hit;

  // Load qualification and completion test on the post-shift history.
  always_comb begin
    valid_load = bus.load && (bus.len_in != '0) && (bus.len_in <= LW'(MAX_LEN));
    bad_load   = bus.load && !valid_load;
    // Any load cycle discards the serial bit.
    consume    = bus.enable && !bus.load && (state_q != StUnarmed);
    mask       = MAX_LEN'(len_mask(32'(len_q)));
    completing = (fill_nxt >= len_q) && ((hist_nxt & mask) == (pattern_q & mask));
    hit        = consume && completing;
  end

  hist_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_hist (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr        (valid_load),
    .shift      (consume),
    .fill_clr   (hit && !overlap_q),
    .bit_in     (bus.i),
    .hist_nxt_o (hist_nxt),
    .fill_nxt_o (fill_nxt)
  );

  // FSM next state, configuration capture, counter and error pulse.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    cnt_d     = cnt_q;
    cfg_err_d = bad_load;

    if (valid_load) begin
      state_d   = StHunt;
      pattern_d = bus.pattern_in;
      len_d     = bus.len_in;
      overlap_d = bus.overlap_en;
    end else if (!bad_load) begin
      case (state_q)
        StUnarmed: state_d = StUnarmed;
        StHunt:    state_d = hit ? StHit : StHunt;
        StHit:     state_d = hit ? StHit : StHunt;
        default:   state_d = StUnarmed;
      endcase
    end

    if (bus.clr_count) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State, configuration and status registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StUnarmed;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.match       = (state_q == StHit);
  assign bus.armed       = (state_q != StUnarmed);
  assign bus.match_count = cnt_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector; a second instance with a 2-bit counter
// shares the stimulus to exercise saturation.
module tb_pattern_detector;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  pattern_detector_if #(.MAX_LEN(8), .CNT_WIDTH(8)) if8 ();
  pattern_detector_if #(.MAX_LEN(8), .CNT_WIDTH(2)) if2 ();

  assign if2.load       = if8.load;
  assign if2.pattern_in = if8.pattern_in;
  assign if2.len_in     = if8.len_in;
  assign if2.overlap_en = if8.overlap_en;
  assign if2.enable     = if8.enable;
  assign if2.i          = if8.i;
  assign if2.clr_count  = if8.clr_count;

  pattern_detector #(.MAX_LEN(8), .CNT_WIDTH(8)) dut8 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (if8)
  );

  pattern_detector #(.MAX_LEN(8), .CNT_WIDTH(2)) dut2 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (if2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if8.enable = 1'b0;
    if8.load   = 1'b0;
    tick();
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    if8.load       = 1'b1;
    if8.pattern_in = pat;
    if8.len_in     = len;
    if8.overlap_en = ov;
    if8.enable     = 1'b0;
    tick();
    if8.load       = 1'b0;
  endtask

  task automatic clear_count();
    if8.clr_count = 1'b1;
    if8.enable    = 1'b0;
    tick();
    if8.clr_count = 1'b0;
  endtask

  task automatic feed(input logic b, input logic exp_match, input string tag);
    if8.enable = 1'b1;
    if8.i      = b;
    tick();
    if8.enable = 1'b0;
    chk(tag, if8.match, exp_match);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] s7;
    logic [6:0] e7;
    logic [4:0] e5;
    logic [7:0] s8;
    logic [7:0] e8;

    if8.load = 1'b0; if8.pattern_in = '0; if8.len_in = '0; if8.overlap_en = 1'b0;
    if8.enable = 1'b0; if8.i = 1'b0; if8.clr_count = 1'b0;
    n_rst = 1'b0;
    #12;
    chk("rst_match", if8.match, 0);
    chk("rst_count", if8.match_count, 0);
    chk("rst_armed", if8.armed, 0);
    chk("rst_cfg_err", if8.cfg_err, 0);
    chk("rst_count2", if2.match_count, 0);
    n_rst = 1'b1;
    tick();
    feed(1'b1, 1'b0, "unarmed_ignore");
    chk("unarmed_armed", if8.armed, 0);

    // 1101, overlapping: hits after bits 4 and 7.
    load_cfg(8'b0000_1101, 4'd4, 1'b1);
    chk("t1_armed", if8.armed, 1);
    chk("t1_cfg_err", if8.cfg_err, 0);
    s7 = 7'b1101101;
    e7 = 7'b0001001;
    for (int k = 6; k >= 0; k--) feed(s7[k], e7[k], "t1_match");
    chk("t1_count", if8.match_count, 2);
    idle();
    chk("t1_drop", if8.match, 0);

    // Same stream, non-overlapping: only bit 4 hits.
    clear_count();
    chk("t2_clear", if8.match_count, 0);
    load_cfg(8'b0000_1101, 4'd4, 1'b0);
    e7 = 7'b0001000;
    for (int k = 6; k >= 0; k--) feed(s7[k], e7[k], "t2_match");
    chk("t2_count", if8.match_count, 1);

    // 111 on a run of five ones, overlapping then not.
    clear_count();
    load_cfg(8'b0000_0111, 4'd3, 1'b1);
    e5 = 5'b00111;
    for (int k = 4; k >= 0; k--) feed(1'b1, e5[k], "t3_ov_match");
    chk("t3_ov_count", if8.match_count, 3);
    clear_count();
    load_cfg(8'b0000_0111, 4'd3, 1'b0);
    e5 = 5'b00100;
    for (int k = 4; k >= 0; k--) feed(1'b1, e5[k], "t3_nov_match");
    chk("t3_nov_count", if8.match_count, 1);

    // Illegal loads leave 111/non-overlap and two buffered ones intact.
    load_cfg(8'h00, 4'd0, 1'b1);
    chk("t4_err0", if8.cfg_err, 1);
    chk("t4_armed0", if8.armed, 1);
    idle();
    chk("t4_err0_drop", if8.cfg_err, 0);
    load_cfg(8'h00, 4'd9, 1'b1);
    chk("t4_err9", if8.cfg_err, 1);
    chk("t4_armed9", if8.armed, 1);
    idle();
    chk("t4_err9_drop", if8.cfg_err, 0);
    feed(1'b1, 1'b1, "t4_resume");
    chk("t4_count", if8.match_count, 2);

    // Full-length pattern is a legal load.
    load_cfg(8'b1010_0101, 4'd8, 1'b0);
    chk("t4_len8_err", if8.cfg_err, 0);
    s8 = 8'b1010_0101;
    e8 = 8'b0000_0001;
    for (int k = 7; k >= 0; k--) feed(s8[k], e8[k], "t4_len8_match");
    chk("t4_len8_count", if8.match_count, 3);

    // Single-bit pattern: every one is a hit; 2-bit counter saturates.
    load_cfg(8'b0000_0001, 4'd1, 1'b1);
    clear_count();
    for (int k = 0; k < 5; k++) begin
      feed(1'b1, 1'b1, "t5_match");
      chk("t5_sat_count", if2.match_count, (k < 3) ? k + 1 : 3);
    end
    chk("t5_wide_count", if8.match_count, 5);
    if8.clr_count = 1'b1;
    feed(1'b1, 1'b1, "t5_clr_match");
    if8.clr_count = 1'b0;
    chk("t5_clr_count2", if2.match_count, 0);
    chk("t5_clr_count8", if8.match_count, 0);

    // Asynchronous reset mid-pattern.
    idle();
    load_cfg(8'b0000_1101, 4'd4, 1'b1);
    s7 = 7'b1101110;
    e7 = 7'b0001000;
    for (int k = 6; k >= 0; k--) feed(s7[k], e7[k], "t6_pre_match");
    chk("t6_pre_count", if8.match_count, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6_rst_match", if8.match, 0);
    chk("t6_rst_count", if8.match_count, 0);
    chk("t6_rst_armed", if8.armed, 0);
    chk("t6_rst_cfg_err", if8.cfg_err, 0);
    chk("t6_rst_count2", if2.match_count, 0);
    #1;
    n_rst = 1'b1;
    s8 = 8'b0000_1101;
    for (int k = 3; k >= 0; k--) feed(s8[k], 1'b0, "t6_post_match");
    chk("t6_post_armed", if8.armed, 0);
    chk("t6_post_count", if8.match_count, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
